// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Processor data-port bus (write strobe, address, store/load data).
// Revision : 1.0
// ============================================================================
interface dmem_responder_if;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;

  modport master (
    output mem_write_i,
    output addr_i,
    output write_data_i,
    input  read_data_o
  );

  modport slave (
    input  mem_write_i,
    input  addr_i,
    input  write_data_i,
    output read_data_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-cycle data memory: 256x32 RAM, LED, switch input and an
//            optional timer (enabled by defining DMEM_TIMER_EN).
// Revision : 1.0
// ============================================================================
module dmem_responder (
  input  logic                   clk_i,
  input  logic                   reset_i,
  dmem_responder_if.slave        bus,
  input  logic [15:0]            sw_i,
  output logic [15:0]            led_o,
  output logic                   timer_irq_o
);

  localparam logic [21:0] c_RAM_PAGE   = 22'h000004;
  localparam logic [29:0] c_LED_WADDR  = 30'h0000_0800;
  localparam logic [29:0] c_SW_WADDR   = 30'h0000_0801;
`ifdef DMEM_TIMER_EN
  localparam logic [29:0] c_TCNT_WADDR = 30'h0000_0802;
  localparam logic [29:0] c_TCMP_WADDR = 30'h0000_0803;
  localparam logic [29:0] c_TSTAT_WADDR = 30'h0000_0804;
`endif

  logic [29:0] w_waddr;
  logic [7:0]  w_ram_idx;
  logic        w_hit_ram;
  logic        w_hit_led;
  logic        w_hit_sw;
  logic        w_wr_en;
  logic        w_unused_ok;

  assign w_waddr     = bus.addr_i[31:2];
  assign w_ram_idx   = bus.addr_i[9:2];
  assign w_hit_ram   = (bus.addr_i[31:10] == c_RAM_PAGE);
  assign w_hit_led   = (w_waddr == c_LED_WADDR);
  assign w_hit_sw    = (w_waddr == c_SW_WADDR);
  // Writes are suppressed while reset is asserted so reset wins everywhere.
  assign w_wr_en     = bus.mem_write_i && reset_i;
  assign w_unused_ok = &{1'b0, bus.addr_i[1:0]};

  // ------------------------------------------------------------------ RAM
  logic [31:0] r_ram [0:255];

  always_ff @(posedge clk_i) begin
    if (w_wr_en && w_hit_ram) begin
      r_ram[w_ram_idx] <= bus.write_data_i;
    end
  end

  // ------------------------------------------------------------------ LED
  logic [15:0] r_led;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_led <= 16'h0000;
    end else if (w_wr_en && w_hit_led) begin
      r_led <= bus.write_data_i[15:0];
    end
  end

  assign led_o = r_led;

  // ------------------------------------------------------------------ switches
  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_sync;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_sw_meta <= 16'h0000;
      r_sw_sync <= 16'h0000;
    end else begin
      r_sw_meta <= sw_i;
      r_sw_sync <= r_sw_meta;
    end
  end

  // ------------------------------------------------------------------ timer
`ifdef DMEM_TIMER_EN
  logic        w_hit_tcnt;
  logic        w_hit_tcmp;
  logic        w_hit_tstat;
  logic [31:0] r_tcnt;
  logic [31:0] r_tcmp;
  logic        r_tstat;

  assign w_hit_tcnt  = (w_waddr == c_TCNT_WADDR);
  assign w_hit_tcmp  = (w_waddr == c_TCMP_WADDR);
  assign w_hit_tstat = (w_waddr == c_TSTAT_WADDR);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_tcnt  <= 32'h0000_0000;
      r_tcmp  <= 32'hFFFF_FFFF;
      r_tstat <= 1'b0;
    end else begin
      if (w_wr_en && w_hit_tcnt) begin
        r_tcnt <= bus.write_data_i;
      end else begin
        r_tcnt <= r_tcnt + 32'd1;
      end
      if (w_wr_en && w_hit_tcmp) begin
        r_tcmp <= bus.write_data_i;
      end
      // Match set has priority over a coincident write-1-to-clear.
      if (r_tcnt == r_tcmp) begin
        r_tstat <= 1'b1;
      end else if (w_wr_en && w_hit_tstat && bus.write_data_i[0]) begin
        r_tstat <= 1'b0;
      end
    end
  end

  assign timer_irq_o = r_tstat;
`else
  assign timer_irq_o = 1'b0;
`endif

  // ------------------------------------------------------------------ read mux
  always_comb begin
    bus.read_data_o = 32'h0000_0000;
    if (w_hit_ram) begin
      bus.read_data_o = r_ram[w_ram_idx];
    end else if (w_hit_led) begin
      bus.read_data_o = {16'h0000, r_led};
    end else if (w_hit_sw) begin
      bus.read_data_o = {16'h0000, r_sw_sync};
`ifdef DMEM_TIMER_EN
    end else if (w_hit_tcnt) begin
      bus.read_data_o = r_tcnt;
    end else if (w_hit_tcmp) begin
      bus.read_data_o = r_tcmp;
    end else if (w_hit_tstat) begin
      bus.read_data_o = {31'h0, r_tstat};
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Scoreboard bench for dmem_responder (timer checks need DMEM_TIMER_EN).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int c_K_RD  = 0;
  localparam int c_K_LED = 1;
  localparam int c_K_IRQ = 2;

  logic        clk;
  logic        reset_n;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;
  int          cyc;
  int          n_checks;
  int          n_errors;

  dmem_responder_if bus_if ();

  dmem_responder dut (
    .clk_i       (clk),
    .reset_i     (reset_n),
    .bus         (bus_if.slave),
    .sw_i        (sw),
    .led_o       (led),
    .timer_irq_o (irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expectations tagged with the cycle in which they must hold.
  int          q_cyc  [$];
  int          q_kind [$];
  logic [31:0] q_exp  [$];
  string       q_name [$];

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    q_cyc.push_back(cyc);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus_if.mem_write_i  = we;
    bus_if.addr_i       = addr;
    bus_if.write_data_i = wd;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    drive(1'b0, addr, 32'h0);
    push(c_K_RD, exp, name);
  endtask

  initial begin : monitor
    logic [31:0] act;
    n_checks = 0;
    n_errors = 0;
    forever begin
      @(negedge clk);
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        case (q_kind[0])
          c_K_RD:  act = bus_if.read_data_o;
          c_K_LED: act = {16'h0, led};
          default: act = {31'h0, irq};
        endcase
        n_checks = n_checks + 1;
        if (act !== q_exp[0] || q_cyc[0] != cyc) begin
          n_errors = n_errors + 1;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", q_name[0], act, q_exp[0], cyc);
        end
        void'(q_cyc.pop_front());
        void'(q_kind.pop_front());
        void'(q_exp.pop_front());
        void'(q_name.pop_front());
      end
    end
  end

  initial begin : stimulus
    reset_n = 1'b0;
    sw      = 16'h0000;
    drive(1'b0, 32'h0, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    push(c_K_LED, 32'h0, "reset_led");
    push(c_K_IRQ, 32'h0, "reset_irq");
    rd(32'h0000_2004, 32'h0, "reset_sw");
    step();

    // RAM write/read, byte offset ignored, range edges
    drive(1'b1, 32'h0000_1004, 32'hDEAD_BEEF); step();
    rd(32'h0000_1004, 32'hDEAD_BEEF, "ram_rd");           step();
    rd(32'h0000_1006, 32'hDEAD_BEEF, "ram_rd_byteoff");   step();
    drive(1'b1, 32'h0000_13FC, 32'hCAFE_F00D);            step();
    drive(1'b1, 32'h0000_1000, 32'h1111_2222);            step();
    rd(32'h0000_13FC, 32'hCAFE_F00D, "ram_top");          step();
    rd(32'h0000_1000, 32'h1111_2222, "ram_bottom");       step();
    rd(32'h0000_1400, 32'h0, "above_ram");                step();
    rd(32'h0000_0FFC, 32'h0, "below_ram");                step();

    // LED
    drive(1'b1, 32'h0000_2000, 32'h1234_ABCD); step();
    push(c_K_LED, 32'h0000_ABCD, "led_out");
    rd(32'h0000_2000, 32'h0000_ABCD, "led_rd");           step();
    drive(1'b1, 32'h0000_2004, 32'hFFFF_FFFF);            step();
    push(c_K_LED, 32'h0000_ABCD, "sw_write_no_led");
    rd(32'h0000_2004, 32'h0, "sw_write_ignored");         step();

    // Switch synchronizer latency
    sw = 16'h00F0;
    rd(32'h0000_2004, 32'h0, "sw_lat0");                  step();
    rd(32'h0000_2004, 32'h0, "sw_lat1");                  step();
    rd(32'h0000_2004, 32'h0000_00F0, "sw_lat2");          step();

    // Unmapped
    rd(32'h0000_3000, 32'h0, "unmapped_rd");              step();
    drive(1'b1, 32'h0000_3000, 32'hFFFF_FFFF);            step();
    push(c_K_LED, 32'h0000_ABCD, "unmapped_wr_led");
    rd(32'h0000_1004, 32'hDEAD_BEEF, "unmapped_wr_ram");  step();

`ifdef DMEM_TIMER_EN
    drive(1'b1, 32'h0000_200C, 32'h5); step();
    drive(1'b1, 32'h0000_2008, 32'h0); step();
    for (int i = 0; i < 7; i++) begin
      rd(32'h0000_2008, i, "tcnt_count");
      push(c_K_IRQ, (i >= 6) ? 32'h1 : 32'h0, "irq_match");
      step();
    end
    drive(1'b1, 32'h0000_2010, 32'h1); step();
    push(c_K_IRQ, 32'h0, "irq_clear");
    rd(32'h0000_2010, 32'h0, "tstat_clear");              step();
    rd(32'h0000_200C, 32'h5, "tcmp_rd");                  step();
    drive(1'b1, 32'h0000_2008, 32'hFFFF_FFFE);            step();
    rd(32'h0000_2008, 32'hFFFF_FFFE, "tcnt_load");        step();
    rd(32'h0000_2008, 32'hFFFF_FFFF, "tcnt_max");         step();
    rd(32'h0000_2008, 32'h0, "tcnt_wrap");                step();
    drive(1'b1, 32'h0000_2008, 32'h100);                  step();
`else
    drive(1'b1, 32'h0000_2008, 32'h7);                    step();
    rd(32'h0000_2008, 32'h0, "tcnt_disabled");
    push(c_K_IRQ, 32'h0, "irq_disabled");                 step();
    rd(32'h0000_200C, 32'h0, "tcmp_disabled");            step();
    rd(32'h0000_2010, 32'h0, "tstat_disabled");           step();
`endif

    // Reset during a write, LED previously all ones
    drive(1'b1, 32'h0000_2000, 32'h0000_FFFF);            step();
    push(c_K_LED, 32'h0000_FFFF, "led_ones");
    reset_n = 1'b0;
    drive(1'b1, 32'h0000_2000, 32'h0000_1234);            step();
    reset_n = 1'b1;
    push(c_K_LED, 32'h0, "rst_led");
    push(c_K_IRQ, 32'h0, "rst_irq");
`ifdef DMEM_TIMER_EN
    rd(32'h0000_2008, 32'h0, "rst_tcnt");                 step();
    rd(32'h0000_2008, 32'h1, "rst_tcnt_resume");          step();
    rd(32'h0000_200C, 32'hFFFF_FFFF, "rst_tcmp");         step();
`else
    rd(32'h0000_2004, 32'h0, "rst_sync");                 step();
`endif
    rd(32'h0000_1004, 32'hDEAD_BEEF, "rst_ram_kept");     step();
    step();
    step();

    if (q_cyc.size() != 0) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_cyc.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL provide the following ports:
- clk_i  input  1  system clock, 10 MHz
- reset_i  input  1  synchronous, active-low reset
- mem_write_i  input  1  write enable from the processor data port
- addr_i  input  32  byte address, taken from the processor ALU result
- write_data_i  input  32  store data
- read_data_o  output  32  load data returned to the processor
- sw_i  input  16  asynchronous board switches
- led_o  output  16  LED register
- timer_irq_o  output  1  timer match flag, level

REQ-002 Only one clock (clk_i) SHALL exist; reset_i SHALL be sampled on the rising edge of clk_i and SHALL be active when 0.

Function
REQ-003 Address decode SHALL use word addresses; addr_i[1:0] SHALL be ignored.
- RAM: 0x0000_1000–0x0000_13FC, 256 x 32 words, index addr_i[9:2]
- LED: 0x0000_2000
- SW: 0x0000_2004
- TCNT: 0x0000_2008
- TCMP: 0x0000_200C
- TSTAT: 0x0000_2010

REQ-004 read_data_o SHALL be combinational from addr_i and the current state, with zero-cycle latency, because a single-cycle core consumes it in the same cycle.
REQ-005 Every write SHALL take effect at the rising edge of clk_i when mem_write_i=1; the new value SHALL be readable in the next cycle.
REQ-006 A RAM read SHALL return the stored word; RAM contents SHALL NOT be reset and SHALL be X until written.
REQ-007 LED:
- write stores write_data_i[15:0]
- read returns {16'h0, led}
- led_o = led register
REQ-008 SW:
- sw_i SHALL pass through a two-flop synchronizer
- read returns {16'h0, sync2}
- writes are ignored
- a sw_i change SHALL be visible 2 cycles later
REQ-009 TCNT SHALL increment by 1 every cycle and SHALL wrap from 0xFFFF_FFFF to 0x0000_0000.
REQ-010 A write to TCNT SHALL load write_data_i. The load SHALL override that cycle's increment, and counting SHALL resume from the loaded value next cycle.
REQ-011 TCMP SHALL be read/write, 32 bits.
REQ-012 When TCNT == TCMP at a clock edge, the match flag TSTAT[0] SHALL be set to 1 at that edge.
REQ-013 TSTAT[0] SHALL be sticky and write-1-to-clear via write_data_i[0]=1. If set and clear coincide, set SHALL win. TSTAT[31:1] SHALL read 0.
REQ-014 timer_irq_o SHALL equal TSTAT[0].
REQ-015 Unmapped addresses:
- reads SHALL return 0x0000_0000
- writes SHALL have no effect
REQ-016 No state other than the addressed location SHALL change on a write.

Reset
REQ-017 While reset_i=0, the following SHALL hold at the next edge:
- led=0, led_o=0
- TCNT=0, TCMP=0xFFFF_FFFF
- TSTAT[0]=0, timer_irq_o=0
- synchronizer flops=0
REQ-018 Reset SHALL take priority over a simultaneous write and over counting.
REQ-019 Reset asserted mid-count SHALL restart TCNT from 0 on the first cycle after reset_i returns to 1.
REQ-020 RAM contents SHALL be unaffected by reset.

Configuration
REQ-021 Macro DMEM_TIMER_EN:
- defined: TCNT, TCMP, TSTAT and timer_irq_o SHALL behave per REQ-009..REQ-014
- undefined: no timer flops SHALL be synthesized, timer addresses SHALL behave as unmapped (read 0, writes ignored), and timer_irq_o SHALL be tied to 0

Verification
REQ-022 Write 0xDEAD_BEEF to 0x0000_1004, then read 0x0000_1004 -> 0xDEAD_BEEF next cycle; read 0x0000_1006 -> same word (byte offset ignored).
REQ-023 Write 0x1234_ABCD to 0x0000_2000 -> led_o=0xABCD next cycle; read 0x0000_2000 -> 0x0000_ABCD.
REQ-024 sw_i set to 0x00F0 -> read 0x0000_2004 returns 0x0000_0000 for 2 cycles, then 0x0000_00F0.
REQ-025 Timer sequence (DMEM_TIMER_EN defined):
- write TCMP=5, write TCNT=0 -> timer_irq_o=1 after the edge where TCNT==5
- write 1 to TSTAT -> timer_irq_o=0
- write TCNT=0xFFFF_FFFE -> reads 0xFFFF_FFFF, then 0x0000_0000 (wrap)
REQ-026 Drive reset_i=0 for 1 cycle with TCNT=0x100, led=0xFFFF and a concurrent write to 0x0000_2000 -> TCNT=0, led_o=0, timer_irq_o=0, and RAM word at 0x0000_1004 still 0xDEAD_BEEF.
REQ-027 Read 0x0000_3000 -> 0x0000_0000. With DMEM_TIMER_EN undefined, write 0x0000_2008=7 then read it -> 0x0000_0000 and timer_irq_o=0.
